alarm_mod_counter: RTL and testbench

//  Parametrised modulo digit counter for the alarm/clock datapath; successor to the fixed 0..59 alarm counter.

---
 rtl/alarm_mod_counter.sv | 94 +++++++++
 tb/tb_alarm_mod_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alarm_mod_counter.sv
// Parametrised modulo digit counter with up/down run mode, manual set mode,
// parallel load, carry/borrow pulses for chaining and a registered alarm match.
module alarm_mod_counter #(
    parameter int unsigned      WIDTH   = 7,
    parameter int unsigned      MODULUS = 60,
    parameter logic [WIDTH-1:0] UNSET   = '1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             mode,
    input  logic             manual_increment,
    input  logic             manual_decrement,
    input  logic             count,
    input  logic             count_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] alarm_value,
    output logic [WIDTH-1:0] out,
    output logic             ripple_carry_out,
    output logic             borrow_out,
    output logic             is_unset,
    output logic             match
);

    // The sentinel must lie outside the count range so it can never be reached by stepping.
    if (UNSET < MODULUS) begin : g_bad_unset
        $error("alarm_mod_counter: UNSET must be >= MODULUS");
    end

    localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] next_out;
    logic             next_carry;
    logic             next_borrow;
    logic             carry_q;
    logic             borrow_q;
    logic             match_q;

    always_comb begin
        next_out    = out_q;
        next_carry  = 1'b0;
        next_borrow = 1'b0;
        if (load) begin
            next_out = (load_value < MOD_W) ? load_value : UNSET;
        end else if (mode) begin
            if (manual_increment && !manual_decrement) begin
                next_out = (out_q == UNSET || out_q == LIMIT) ? '0 : out_q + ONE;
            end else if (manual_decrement && !manual_increment) begin
                next_out = (out_q == UNSET || out_q == '0) ? LIMIT : out_q - ONE;
            end
        end else if (count && out_q != UNSET) begin
            if (!count_down) begin
                if (out_q == LIMIT) begin
                    next_out   = '0;
                    next_carry = 1'b1;
                end else begin
                    next_out = out_q + ONE;
                end
            end else begin
                if (out_q == '0) begin
                    next_out    = LIMIT;
                    next_borrow = 1'b1;
                end else begin
                    next_out = out_q - ONE;
                end
            end
        end
    end

    // match is computed from the next state so it rises with out, not a cycle later.
    always_ff @(posedge clk) begin
        if (clear) begin
            out_q    <= UNSET;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            out_q    <= next_out;
            carry_q  <= next_carry;
            borrow_q <= next_borrow;
            match_q  <= (next_out == alarm_value) && (next_out != UNSET);
        end
    end

    assign out              = out_q;
    assign ripple_carry_out = carry_q;
    assign borrow_out       = borrow_q;
    assign is_unset         = (out_q == UNSET);
    assign match            = match_q;

endmodule

// File: tb/tb_alarm_mod_counter.sv
// Directed bench for alarm_mod_counter: default 0..59 instance plus a 0..23 (5-bit) instance.
module tb_alarm_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear, clear_b;
    logic       mode, manual_increment, manual_decrement, count, count_down, load;
    logic [6:0] load_value, alarm_value, out;
    logic       ripple_carry_out, borrow_out, is_unset, match;
    logic [4:0] load_value_b, alarm_value_b, out_b;
    logic       carry_b, borrow_b, is_unset_b, match_b;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    alarm_mod_counter dut (
        .clk(clk), .clear(clear), .mode(mode),
        .manual_increment(manual_increment), .manual_decrement(manual_decrement),
        .count(count), .count_down(count_down), .load(load),
        .load_value(load_value), .alarm_value(alarm_value), .out(out),
        .ripple_carry_out(ripple_carry_out), .borrow_out(borrow_out),
        .is_unset(is_unset), .match(match)
    );

    alarm_mod_counter #(.WIDTH(5), .MODULUS(24)) dut_b (
        .clk(clk), .clear(clear_b), .mode(mode),
        .manual_increment(manual_increment), .manual_decrement(manual_decrement),
        .count(count), .count_down(count_down), .load(load),
        .load_value(load_value_b), .alarm_value(alarm_value_b), .out(out_b),
        .ripple_carry_out(carry_b), .borrow_out(borrow_b),
        .is_unset(is_unset_b), .match(match_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the default instance: out, carry, borrow, match.
    task automatic check_a(input string tag, input int o, input int c, input int b, input int m);
        check({tag, ".out"},    32'(out), 32'(o));
        check({tag, ".carry"},  32'(ripple_carry_out), 32'(c));
        check({tag, ".borrow"}, 32'(borrow_out), 32'(b));
        check({tag, ".match"},  32'(match), 32'(m));
    endtask

    task automatic check_b(input string tag, input int o, input int c, input int b);
        check({tag, ".out"},    32'(out_b), 32'(o));
        check({tag, ".carry"},  32'(carry_b), 32'(c));
        check({tag, ".borrow"}, 32'(borrow_b), 32'(b));
    endtask

    initial begin
        clear = 1'b1; clear_b = 1'b1;
        mode = 0; manual_increment = 0; manual_decrement = 0;
        count = 0; count_down = 0; load = 0;
        load_value = '0; alarm_value = 7'd100; load_value_b = '0; alarm_value_b = 5'd30;
        #2;

        // T1 reset
        step();
        clear = 0; clear_b = 0;
        check_a("t1_reset", 127, 0, 0, 0);
        check("t1_unset", 32'(is_unset), 1);

        // T2 set mode
        mode = 1; manual_increment = 1; count = 1;
        step(); check_a("t2_inc_from_unset", 0, 0, 0, 0);
        check("t2_set", 32'(is_unset), 0);
        manual_increment = 0; manual_decrement = 1;
        step(); check_a("t2_dec_from_0", 59, 0, 0, 0);
        manual_increment = 1;
        step(); check_a("t2_both_hold", 59, 0, 0, 0);
        manual_increment = 1; manual_decrement = 0;
        step(); check_a("t2_inc_from_limit", 0, 0, 0, 0);
        manual_increment = 0; manual_decrement = 1;
        clear = 1; step(); clear = 0;
        step(); check_a("t2_dec_from_unset", 59, 0, 0, 0);
        step(); check_a("t2_dec", 58, 0, 0, 0);
        manual_decrement = 0; mode = 0; count = 0;

        // T3 run up wrap
        load = 1; load_value = 7'd58;
        step(); check_a("t3_load", 58, 0, 0, 0);
        load = 0; count = 1;
        step(); check_a("t3_up1", 59, 0, 0, 0);
        step(); check_a("t3_wrap", 0, 1, 0, 0);
        step(); check_a("t3_after", 1, 0, 0, 0);
        count = 0;
        step(); check_a("t3_idle", 1, 0, 0, 0);

        // T4 run down wrap
        count_down = 1; count = 1;
        step(); check_a("t4_dn1", 0, 0, 0, 0);
        step(); check_a("t4_wrap", 59, 0, 1, 0);
        step(); check_a("t4_after", 58, 0, 0, 0);
        count = 0; count_down = 0;

        // T5 edge loads and counting while unset; load beats set mode
        load = 1; load_value = 7'd60; mode = 1; manual_increment = 1;
        step(); check_a("t5_load60", 127, 0, 0, 0);
        check("t5_unset", 32'(is_unset), 1);
        load_value = 7'd59;
        step(); check_a("t5_load59", 59, 0, 0, 0);
        load_value = 7'd127;
        step(); check_a("t5_load127", 127, 0, 0, 0);
        load = 0; mode = 0; manual_increment = 0; count = 1;
        step(); check_a("t5_cnt_unset", 127, 0, 0, 0);
        count_down = 1;
        step(); check_a("t5_cnt_unset_dn", 127, 0, 0, 0);
        count = 0; count_down = 0;

        // T6 match
        alarm_value = 7'd5; load = 1; load_value = 7'd3;
        step(); check_a("t6_load3", 3, 0, 0, 0);
        load = 0; count = 1;
        step(); check_a("t6_4", 4, 0, 0, 0);
        step(); check_a("t6_5", 5, 0, 0, 1);
        step(); check_a("t6_6", 6, 0, 0, 0);
        count = 0; alarm_value = 7'd6;
        step(); check_a("t6_alarm_change", 6, 0, 0, 1);
        alarm_value = 7'd127; clear = 1;
        step(); check_a("t6_unset_nomatch", 127, 0, 0, 0);
        clear = 0;

        // Clear on the wrap cycle
        load = 1; load_value = 7'd59;
        step(); load = 0; count = 1; clear = 1;
        step(); check_a("t6_clear_on_wrap", 127, 0, 0, 0);
        clear = 0; count = 0;
        // Clear while the carry pulse is high
        load = 1; load_value = 7'd59;
        step(); load = 0; count = 1;
        step(); check_a("t6_pulse", 0, 1, 0, 0);
        clear = 1;
        step(); check_a("t6_clear_mid_pulse", 127, 0, 0, 0);
        clear = 0; count = 0;

        // Second instance, modulus 24 on 5 bits
        clear_b = 1;
        step(); clear_b = 0;
        check_b("b_reset", 31, 0, 0);
        check("b_unset", 32'(is_unset_b), 1);
        load = 1; load_value_b = 5'd22;
        step(); check_b("b_load22", 22, 0, 0);
        load = 0; count = 1;
        step(); check_b("b_23", 23, 0, 0);
        step(); check_b("b_wrap", 0, 1, 0);
        step(); check_b("b_1", 1, 0, 0);
        count = 0; load = 1; load_value_b = 5'd0;
        step(); check_b("b_load0", 0, 0, 0);
        load = 0; count = 1; count_down = 1;
        step(); check_b("b_dn_wrap", 23, 0, 1);
        step(); check_b("b_22", 22, 0, 0);
        count = 0; count_down = 0; load = 1; load_value_b = 5'd24;
        step(); check_b("b_load24", 31, 0, 0);
        check("b_unset2", 32'(is_unset_b), 1);
        load = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
